// File: rtl/matrix_inverse_checker.sv
// matrix_inverse_checker: loads an integer matrix A and a Q8.8 candidate inverse B.
// It forms C = A*B with one multiply-accumulate per cycle, then reports how far C
// lies from the Q8.8 identity matrix.
module matrix_inverse_checker #(
  parameter int TOL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_count,
  output logic [15:0] max_err
);

  typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [4:0]         word_idx;
  logic [1:0]         i_idx, j_idx, k_idx;
  logic signed [7:0]  a_mem [9];
  logic signed [15:0] b_mem [9];
  logic signed [25:0] acc;
  logic [3:0]         run_err_count;
  logic [15:0]        run_max_err;

  logic               accept;
  logic               last_word;
  logic               last_mac;
  logic [4:0]         b_addr_load;
  logic [3:0]         a_addr;
  logic [3:0]         b_addr_calc;
  logic signed [23:0] a_ext;
  logic signed [23:0] b_ext;
  logic signed [23:0] product;
  logic signed [25:0] mac_sum;
  logic signed [25:0] target;
  logic signed [25:0] diff;
  logic [25:0]        err_abs;
  logic [15:0]        err_sat;
  logic               elem_bad;
  logic [3:0]         err_count_upd;
  logic [15:0]        max_err_upd;

  assign accept      = in_valid && (state == LOAD);
  assign last_word   = (word_idx == 5'd17);
  assign last_mac    = (i_idx == 2'd2) && (j_idx == 2'd2) && (k_idx == 2'd2);
  assign b_addr_load = word_idx - 5'd9;

  // Next-state and handshake outputs: words are taken only in LOAD; done marks the DONE cycle.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && last_word) state_nxt = CALC;
      end
      CALC: begin
        if (last_mac) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // MAC datapath: full-width product and sum, and error against the identity target.
  always_comb begin
    a_addr        = {2'b00, i_idx} + {2'b00, i_idx} + {2'b00, i_idx} + {2'b00, k_idx};
    b_addr_calc   = {2'b00, k_idx} + {2'b00, k_idx} + {2'b00, k_idx} + {2'b00, j_idx};
    a_ext         = {{16{a_mem[a_addr][7]}}, a_mem[a_addr]};
    b_ext         = {{8{b_mem[b_addr_calc][15]}}, b_mem[b_addr_calc]};
    product       = a_ext * b_ext;
    mac_sum       = acc + {{2{product[23]}}, product};
    target        = (i_idx == j_idx) ? 26'sd256 : 26'sd0;
    diff          = mac_sum - target;
    err_abs       = diff[25] ? -diff : diff;
    err_sat       = (err_abs[25:16] != 10'd0) ? 16'hFFFF : err_abs[15:0];
    elem_bad      = (err_abs > 26'(TOL));
    err_count_upd = run_err_count + {3'b000, elem_bad};
    max_err_upd   = (err_sat > run_max_err) ? err_sat : run_max_err;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Matrix storage: the first nine words fill A (low byte), the next nine fill B.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      if (word_idx < 5'd9) a_mem[word_idx[3:0]]    <= in_data[7:0];
      else                 b_mem[b_addr_load[3:0]] <= in_data;
    end
  end

  // Word counting, MAC sequencing, running error statistics and the held result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx      <= 5'd0;
      i_idx         <= 2'd0;
      j_idx         <= 2'd0;
      k_idx         <= 2'd0;
      acc           <= 26'sd0;
      run_err_count <= 4'd0;
      run_max_err   <= 16'd0;
      pass          <= 1'b0;
      err_count     <= 4'd0;
      max_err       <= 16'd0;
    end else begin
      unique case (state)
        LOAD: begin
          if (accept) begin
            if (last_word) begin
              word_idx      <= 5'd0;
              i_idx         <= 2'd0;
              j_idx         <= 2'd0;
              k_idx         <= 2'd0;
              acc           <= 26'sd0;
              run_err_count <= 4'd0;
              run_max_err   <= 16'd0;
            end else begin
              word_idx <= word_idx + 5'd1;
            end
          end
        end
        CALC: begin
          if (k_idx == 2'd2) begin
            acc           <= 26'sd0;
            k_idx         <= 2'd0;
            run_err_count <= err_count_upd;
            run_max_err   <= max_err_upd;
            if (j_idx == 2'd2) begin
              j_idx <= 2'd0;
              i_idx <= (i_idx == 2'd2) ? 2'd0 : i_idx + 2'd1;
            end else begin
              j_idx <= j_idx + 2'd1;
            end
            if (last_mac) begin
              pass      <= (err_count_upd == 4'd0);
              err_count <= err_count_upd;
              max_err   <= max_err_upd;
            end
          end else begin
            acc   <= mac_sum;
            k_idx <= k_idx + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_inverse_checker.sv
// tb_matrix_inverse_checker: directed and randomized checks of matrix_inverse_checker
// against a plain-arithmetic model of A*B compared with the Q8.8 identity.
module tb_matrix_inverse_checker;

  localparam int TOL = 4;

  typedef int mat_t [9];

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        done;
  logic        pass;
  logic [3:0]  err_count;
  logic [15:0] max_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  matrix_inverse_checker #(.TOL(TOL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .max_err   (max_err)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: full matrix product, error against 256*I, count above TOL, saturating max.
  function automatic void model(input mat_t a, input mat_t b, output int cnt, output int mx);
    int c, e;
    cnt = 0;
    mx  = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        c = 0;
        for (int k = 0; k < 3; k++) c += a[i*3+k] * b[k*3+j];
        e = c - ((i == j) ? 256 : 0);
        if (e < 0) e = -e;
        if (e > TOL) cnt++;
        if (e > mx) mx = e;
      end
    end
    if (mx > 65535) mx = 65535;
  endfunction

  // Streams A then B, then waits (bounded) for done; reports latency and handshake anomalies.
  task automatic run_check(input mat_t a, input mat_t b, input bit rand_valid, input bit garbage,
                           output int lat, output int ready_bad, output int early_done,
                           output int first_cyc, output int done_cyc);
    int n, n_cyc, guard;
    n = 0; n_cyc = 0; guard = 0;
    lat = -1; ready_bad = 0; early_done = 0; first_cyc = -1; done_cyc = -1;
    while (n < 18 && guard < 500) begin
      @(negedge clk);
      guard++;
      in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!in_valid)  in_data = 16'($urandom);
      else if (n < 9) in_data = {8'($urandom), 8'(a[n])};
      else            in_data = 16'(b[n-9]);
      if (done) early_done++;
      if (in_valid && in_ready) begin
        if (n == 0) first_cyc = cyc;
        n_cyc = cyc;
        n++;
      end
    end
    if (n == 18) begin
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        in_valid = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data  = 16'($urandom);
        if (in_ready) ready_bad++;
        if (done) begin
          lat      = cyc - n_cyc;
          done_cyc = cyc;
          in_valid = 1'b0;
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pass: got %b expected 0", pass); end
    tests_run++; if (err_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_err_count: got %0d expected 0", err_count); end
    tests_run++; if (max_err !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_max_err: got %0d expected 0", max_err); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    mat_t a, b;
    int lat, rb, ed, fc, dc;
    a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    b = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    run_check(a, b, 1'b0, 1'b0, lat, rb, ed, fc, dc);
    tests_run++; if (lat !== 28) begin tests_failed++; $display("[TB] FAIL ident_latency: got %0d expected 28", lat); end
    tests_run++; if (rb !== 0) begin tests_failed++; $display("[TB] FAIL ident_ready_low: got %0d ready cycles expected 0", rb); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("[TB] FAIL ident_pass: got %b expected 1", pass); end
    tests_run++; if (err_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL ident_err_count: got %0d expected 0", err_count); end
    tests_run++; if (max_err !== 16'd0) begin tests_failed++; $display("[TB] FAIL ident_max_err: got %0d expected 0", max_err); end
    @(negedge clk);
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL ident_done_pulse: got %b expected 0", done); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("[TB] FAIL ident_pass_hold: got %b expected 1", pass); end
  endtask

  task automatic test_diag_scaled();
    mat_t a, b;
    int lat, rb, ed, fc, dc;
    a = '{2, 0, 0, 0, -2, 0, 0, 0, 2};
    b = '{128, 0, 0, 0, -128, 0, 0, 0, 128};
    run_check(a, b, 1'b0, 1'b0, lat, rb, ed, fc, dc);
    tests_run++; if (lat !== 28) begin tests_failed++; $display("[TB] FAIL diag_latency: got %0d expected 28", lat); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("[TB] FAIL diag_pass: got %b expected 1", pass); end
    tests_run++; if (err_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL diag_err_count: got %0d expected 0", err_count); end
    tests_run++; if (max_err !== 16'd0) begin tests_failed++; $display("[TB] FAIL diag_max_err: got %0d expected 0", max_err); end
  endtask

  task automatic test_tolerance();
    mat_t a, b;
    int lat, rb, ed, fc, dc;
    a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    b = '{256, 5, 0, 0, 256, 0, 0, 0, 256};
    run_check(a, b, 1'b0, 1'b0, lat, rb, ed, fc, dc);
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("[TB] FAIL tol5_pass: got %b expected 0", pass); end
    tests_run++; if (err_count !== 4'd1) begin tests_failed++; $display("[TB] FAIL tol5_err_count: got %0d expected 1", err_count); end
    tests_run++; if (max_err !== 16'd5) begin tests_failed++; $display("[TB] FAIL tol5_max_err: got %0d expected 5", max_err); end
    b[1] = 4;
    run_check(a, b, 1'b0, 1'b0, lat, rb, ed, fc, dc);
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("[TB] FAIL tol4_pass: got %b expected 1", pass); end
    tests_run++; if (err_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL tol4_err_count: got %0d expected 0", err_count); end
    tests_run++; if (max_err !== 16'd4) begin tests_failed++; $display("[TB] FAIL tol4_max_err: got %0d expected 4", max_err); end
  endtask

  task automatic test_saturate();
    mat_t a, b;
    int lat, rb, ed, fc, dc;
    for (int k = 0; k < 9; k++) begin
      a[k] = 127;
      b[k] = -32768;
    end
    run_check(a, b, 1'b0, 1'b0, lat, rb, ed, fc, dc);
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("[TB] FAIL sat_pass: got %b expected 0", pass); end
    tests_run++; if (err_count !== 4'd9) begin tests_failed++; $display("[TB] FAIL sat_err_count: got %0d expected 9", err_count); end
    tests_run++; if (max_err !== 16'hFFFF) begin tests_failed++; $display("[TB] FAIL sat_max_err: got %h expected ffff", max_err); end
  endtask

  task automatic test_random_handshake();
    mat_t a, b;
    int lat, rb, ed, fc, dc;
    a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    b = '{256, 0, 0, 0, 256, 0, 0, 0, 256};
    run_check(a, b, 1'b1, 1'b1, lat, rb, ed, fc, dc);
    tests_run++; if (lat !== 28) begin tests_failed++; $display("[TB] FAIL hs_latency: got %0d expected 28", lat); end
    tests_run++; if (rb !== 0) begin tests_failed++; $display("[TB] FAIL hs_ready_low: got %0d ready cycles expected 0", rb); end
    tests_run++; if (pass !== 1'b1) begin tests_failed++; $display("[TB] FAIL hs_pass: got %b expected 1", pass); end
    tests_run++; if (err_count !== 4'd0) begin tests_failed++; $display("[TB] FAIL hs_err_count: got %0d expected 0", err_count); end
    tests_run++; if (max_err !== 16'd0) begin tests_failed++; $display("[TB] FAIL hs_max_err: got %0d expected 0", max_err); end
  endtask

  task automatic test_reset_midload();
    mat_t a, b;
    int lat, rb, ed, fc, dc, early;
    early = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      if (done) early++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    if (done) early++;
    @(negedge clk);
    rst = 1'b0;
    if (done) early++;
    a = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    b = '{256, 5, 0, 0, 256, 0, 0, 0, 256};
    run_check(a, b, 1'b0, 1'b0, lat, rb, ed, fc, dc);
    tests_run++; if (early + ed !== 0) begin tests_failed++; $display("[TB] FAIL rstmid_early_done: got %0d pulses expected 0", early + ed); end
    tests_run++; if (lat !== 28) begin tests_failed++; $display("[TB] FAIL rstmid_latency: got %0d expected 28", lat); end
    tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_pass: got %b expected 0", pass); end
    tests_run++; if (err_count !== 4'd1) begin tests_failed++; $display("[TB] FAIL rstmid_err_count: got %0d expected 1", err_count); end
    tests_run++; if (max_err !== 16'd5) begin tests_failed++; $display("[TB] FAIL rstmid_max_err: got %0d expected 5", max_err); end
  endtask

  task automatic test_back_to_back();
    mat_t a, b;
    int lat, rb, ed, fc, dc, prev_dc, cnt, mx;
    bit rv;
    prev_dc = -1;
    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < 9; k++) begin
        if (it % 2 == 0) begin
          a[k] = int'($urandom_range(0, 255)) - 128;
          b[k] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          a[k] = (k % 4 == 0) ? 1 : 0;
          b[k] = ((k % 4 == 0) ? 256 : 0) + int'($urandom_range(0, 12)) - 6;
        end
      end
      rv = (it >= 6);
      model(a, b, cnt, mx);
      run_check(a, b, rv, 1'b0, lat, rb, ed, fc, dc);
      tests_run++; if (lat !== 28) begin tests_failed++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 28", it, lat); end
      tests_run++; if (pass !== (cnt == 0)) begin tests_failed++; $display("[TB] FAIL b2b_pass[%0d]: got %b expected %b", it, pass, cnt == 0); end
      tests_run++; if (err_count !== 4'(cnt)) begin tests_failed++; $display("[TB] FAIL b2b_err_count[%0d]: got %0d expected %0d", it, err_count, cnt); end
      tests_run++; if (max_err !== 16'(mx)) begin tests_failed++; $display("[TB] FAIL b2b_max_err[%0d]: got %0d expected %0d", it, max_err, mx); end
      if (!rv && it > 0) begin
        tests_run++; if (fc !== prev_dc + 1) begin tests_failed++; $display("[TB] FAIL b2b_first_word[%0d]: got cycle %0d expected %0d", it, fc, prev_dc + 1); end
      end
      prev_dc = dc;
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_identity();
    test_diag_scaled();
    test_tolerance();
    test_saturate();
    test_random_handshake();
    test_reset_midload();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
